svc_mem_sram_pipe: RTL and testbench
====================================

SVC_MEM_SRAM_PIPE -- requirements
Module: svc_mem_sram_pipe

Interface
REQ-001 The block SHALL have parameter DW, 32, data width in bits; a multiple of 8, minimum 8.
REQ-002 The block SHALL have parameter AW, 10, word-address width; depth is 2**AW words.
REQ-003 The block SHALL have parameter RD_LAT, 1, read latency in cycles; legal range 1..4.
REQ-004 The block SHALL have parameter WR_FIRST, 0, same-cycle same-word read/write mode: 0 returns old data, 1 returns new data.
REQ-005 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port init_done  output  1  high once the power-on clear is complete.
REQ-008 The block SHALL have port rd_addr  input  32  byte address of the read.
REQ-009 The block SHALL have port rd_valid  input  1  read request.
REQ-010 The block SHALL have port rd_ready  output  1  read accept; equals init_done.
REQ-011 The block SHALL have port rd_data  output  DW  read data.
REQ-012 The block SHALL have port rd_data_valid  output  1  rd_data is valid this cycle.
REQ-013 The block SHALL have port wr_addr  input  32  byte address of the write.
REQ-014 The block SHALL have port wr_data  input  DW  write data.
REQ-015 The block SHALL have port wr_strb  input  DW/8  byte enables; bit i covers wr_data[8i+7:8i].
REQ-016 The block SHALL have port wr_valid  input  1  write request.
REQ-017 The block SHALL have port wr_ready  output  1  write accept; equals init_done.

Function
REQ-018 Word index SHALL be addr[AW+B-1:B], B=log2(DW/8); bits below B and above AW+B-1 are ignored, so out-of-range addresses alias/wrap.
REQ-019 A read SHALL be accepted on a rising edge where rd_valid && rd_ready; one read accepted per cycle, fully pipelined.
REQ-020 An accepted read SHALL produce rd_data_valid=1 with its data exactly RD_LAT cycles after the accepting edge, in issue order.
REQ-021 When rd_data_valid is 0, rd_data SHALL hold its last value.
REQ-022 A write SHALL be accepted on a rising edge where wr_valid && wr_ready, updating only strobed bytes; wr_strb=0 leaves memory unchanged.
REQ-023 A read accepted on the same edge as a write to the same word SHALL return pre-write data if WR_FIRST=0, or the byte-merged new word if WR_FIRST=1.
REQ-024 A read accepted on any edge after a write's accepting edge SHALL return the written data regardless of RD_LAT.
REQ-025 The controller SHALL have two states: CLEAR and READY.
REQ-026 In CLEAR the block SHALL write zero to one word per cycle at indices 0..2**AW-1 ascending, holding init_done, rd_ready and wr_ready low.
REQ-027 The block SHALL transition CLEAR->READY on the edge that clears index 2**AW-1; init_done rises on that edge.
REQ-028 In READY the block SHALL remain until reset; no other transitions.
REQ-029 Requests presented while not ready SHALL be ignored, not queued.

Reset
REQ-030 On rst_n low the block SHALL immediately enter CLEAR with clear index 0.
REQ-031 On rst_n low the block SHALL immediately drive init_done=0, rd_ready=0, wr_ready=0, rd_data_valid=0 and rd_data=0.
REQ-032 On rst_n low the block SHALL discard all in-flight reads.
REQ-033 Reset asserted mid-clear or mid-read SHALL restart the clear from index 0; no partial read SHALL emerge afterwards.
REQ-034 The memory array itself SHALL not be asynchronously reset; zeroing is solely by the CLEAR sequence.

Verification
REQ-035 The bench SHALL run with DW=32, AW=4, RD_LAT=2 unless a scenario states otherwise.
REQ-036 The bench SHALL cover the init clear: release reset -> init_done rises exactly 16 cycles later; read 0x3C -> 0x0000_0000.
REQ-037 The bench SHALL cover strobed writes: writes to 0x10 of 0xAA00_0000/1000, 0x00BB_0000/0100, 0x0000_CC00/0010, 0x0000_00DD/0001 -> read 0x10 returns 0xAABB_CCDD with rd_data_valid high exactly 2 cycles after accept.
REQ-038 The bench SHALL cover pipelining: back-to-back reads 0x00, 0x04, 0x08 holding 0x1111_1111, 0x2222_2222, 0x3333_3333 -> three consecutive valid cycles in that order.
REQ-039 The bench SHALL cover read-during-write: word 0x30=0x1, then same edge read 0x30 and write 0x2 -> WR_FIRST=0 returns 0x1, WR_FIRST=1 returns 0x2; next read returns 0x2.
REQ-040 The bench SHALL cover aliasing: write 0x4000_0008=0xCAFE_BABE -> read 0x08 returns 0xCAFE_BABE.
REQ-041 The bench SHALL cover reset mid-operation: assert rst_n low with a read in flight and at clear index 7 -> rd_data_valid never pulses for that read; init_done rises 16 cycles after release.
REQ-042 The bench SHALL cover latency: repeat the strobe scenario with RD_LAT=1 and RD_LAT=4 -> rd_data_valid exactly 1 and 4 cycles after accept.

Source files
------------

// File: rtl/svc_mem_sram_pipe.sv
// Single-port-per-direction SRAM with a pipelined read path, byte-strobed writes
// and a power-on clear sequence that zeroes every word before accepting traffic.
module svc_mem_sram_pipe #(
    parameter int DW       = 32,
    parameter int AW       = 10,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            init_done,
    input  logic [31:0]     rd_addr,
    input  logic            rd_valid,
    output logic            rd_ready,
    output logic [DW-1:0]   rd_data,
    output logic            rd_data_valid,
    input  logic [31:0]     wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_strb,
    input  logic            wr_valid,
    output logic            wr_ready
);

    localparam int NB    = DW / 8;
    localparam int B     = $clog2(NB);
    localparam int DEPTH = 2 ** AW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] clr_idx;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          rd_fire;
    logic          wr_fire;
    logic [DW-1:0] rd_word;

    logic [DW-1:0]     rd_word_p [RD_LAT];
    logic [RD_LAT-1:0] vld_p;

    // Address bits outside the word index are intentionally ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{rd_addr, wr_addr};

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [NB-1:0] strb);
        logic [DW-1:0] m;
        m = old_w;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

    assign init_done = (state == ST_READY);
    assign rd_ready  = init_done;
    assign wr_ready  = init_done;

    assign rd_idx  = rd_addr[AW+B-1:B];
    assign wr_idx  = wr_addr[AW+B-1:B];
    assign rd_fire = rd_valid && rd_ready;
    assign wr_fire = wr_valid && wr_ready;

    // Clear controller: one word per cycle, then parks in READY until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(DEPTH - 1)) state <= ST_READY;
        end
    end

    // Storage has no reset; zeroing comes only from the clear sequence.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_fire) begin
            mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data, wr_strb);
        end
    end

    // Write-first mode forwards the byte-merged word on a same-word collision.
    always_comb begin
        rd_word = mem[rd_idx];
        if ((WR_FIRST != 0) && wr_fire && (wr_idx == rd_idx)) begin
            rd_word = merge_bytes(mem[rd_idx], wr_data, wr_strb);
        end
    end

    // Stage p0 captures the array on the accepting edge; later stages delay it.
    always_ff @(posedge clk) begin
        if (rd_fire) rd_word_p[0] <= rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_word_p[i] <= rd_word_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Output stage: rd_data only moves when a read completes, otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= vld_p[RD_LAT-1];
            if (vld_p[RD_LAT-1]) rd_data <= rd_word_p[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_svc_mem_sram_pipe.sv
// Directed bench: four instances share stimulus (lat2/old-data, lat2/new-data,
// lat1, lat4) and each output is checked against its own latency and mode.
module tb_svc_mem_sram_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_valid = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        wr_valid = 1'b0;

    logic [3:0]       idn;
    logic [3:0]       rdy;
    logic [3:0]       wry;
    logic [3:0]       vld;
    logic [3:0][31:0] dat;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_d [4];

    always #5 clk = ~clk;

    svc_mem_sram_pipe #(.DW(32), .AW(4), .RD_LAT(2), .WR_FIRST(0)) u_l2 (
        .clk(clk), .rst_n(rst_n), .init_done(idn[0]),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rdy[0]),
        .rd_data(dat[0]), .rd_data_valid(vld[0]),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_valid(wr_valid), .wr_ready(wry[0]));

    svc_mem_sram_pipe #(.DW(32), .AW(4), .RD_LAT(2), .WR_FIRST(1)) u_wf (
        .clk(clk), .rst_n(rst_n), .init_done(idn[1]),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rdy[1]),
        .rd_data(dat[1]), .rd_data_valid(vld[1]),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_valid(wr_valid), .wr_ready(wry[1]));

    svc_mem_sram_pipe #(.DW(32), .AW(4), .RD_LAT(1), .WR_FIRST(0)) u_l1 (
        .clk(clk), .rst_n(rst_n), .init_done(idn[2]),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rdy[2]),
        .rd_data(dat[2]), .rd_data_valid(vld[2]),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_valid(wr_valid), .wr_ready(wry[2]));

    svc_mem_sram_pipe #(.DW(32), .AW(4), .RD_LAT(4), .WR_FIRST(0)) u_l4 (
        .clk(clk), .rst_n(rst_n), .init_done(idn[3]),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rdy[3]),
        .rd_data(dat[3]), .rd_data_valid(vld[3]),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_valid(wr_valid), .wr_ready(wry[3]));

    function automatic int lat_of(input int j);
        case (j)
            0: return 2;
            1: return 2;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    // Stimulus helpers: entered and left 1 time unit after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_addr = a; wr_data = d; wr_strb = s; wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] a);
        rd_addr = a; rd_valid = 1'b1;
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            n_vec += 5;
            if (idn[j] !== 1'b0) begin n_err++; $display("FAIL rst_init_done inst=%0d got=%b exp=0", j, idn[j]); end
            if (rdy[j] !== 1'b0) begin n_err++; $display("FAIL rst_rd_ready inst=%0d got=%b exp=0", j, rdy[j]); end
            if (wry[j] !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready inst=%0d got=%b exp=0", j, wry[j]); end
            if (vld[j] !== 1'b0) begin n_err++; $display("FAIL rst_rd_data_valid inst=%0d got=%b exp=0", j, vld[j]); end
            if (dat[j] !== 32'h0) begin n_err++; $display("FAIL rst_rd_data inst=%0d got=%h exp=0", j, dat[j]); end
        end
        rst_n = 1'b1;
        rd_addr = 32'h3C; rd_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 15) rd_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
                n_vec += 3;
                if (idn[j] !== (k == 16)) begin n_err++; $display("FAIL clear_init_done inst=%0d k=%0d got=%b exp=%b", j, k, idn[j], k == 16); end
                if (rdy[j] !== (k == 16)) begin n_err++; $display("FAIL clear_rd_ready inst=%0d k=%0d got=%b exp=%b", j, k, rdy[j], k == 16); end
                if (vld[j] !== 1'b0) begin n_err++; $display("FAIL clear_ignored_read inst=%0d k=%0d got=%b exp=0", j, k, vld[j]); end
            end
        end
        issue_read(32'h3C);
        for (int j = 0; j < 4; j++) exp_d[j] = 32'h0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (vld[j] !== (k == lat_of(j))) begin n_err++; $display("FAIL clear_read_valid inst=%0d k=%0d got=%b", j, k, vld[j]); end
                if (k >= lat_of(j)) begin
                    n_vec++;
                    if (dat[j] !== exp_d[j]) begin n_err++; $display("FAIL clear_read_data inst=%0d got=%h exp=%h", j, dat[j], exp_d[j]); end
                end
            end
        end
    endtask

    task automatic test_strobe_latency;
        do_write(32'h10, 32'hAA00_0000, 4'b1000);
        do_write(32'h10, 32'h00BB_0000, 4'b0100);
        do_write(32'h10, 32'h0000_CC00, 4'b0010);
        do_write(32'h10, 32'h0000_00DD, 4'b0001);
        do_write(32'h10, 32'hFFFF_FFFF, 4'b0000);
        issue_read(32'h10);
        for (int j = 0; j < 4; j++) exp_d[j] = 32'hAABB_CCDD;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (vld[j] !== (k == lat_of(j))) begin n_err++; $display("FAIL strobe_valid inst=%0d k=%0d got=%b exp=%b", j, k, vld[j], k == lat_of(j)); end
                if (k >= lat_of(j)) begin
                    n_vec++;
                    if (dat[j] !== exp_d[j]) begin n_err++; $display("FAIL strobe_data inst=%0d k=%0d got=%h exp=%h", j, k, dat[j], exp_d[j]); end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [3];
        int          idx;
        logic        ev;
        words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
        do_write(32'h00, words[0], 4'hF);
        do_write(32'h04, words[1], 4'hF);
        do_write(32'h08, words[2], 4'hF);
        for (int k = 1; k <= 8; k++) begin
            if (k <= 3) begin rd_addr = 32'(4 * (k - 1)); rd_valid = 1'b1; end
            else rd_valid = 1'b0;
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                idx = k - lat_of(j) - 1;
                ev  = (idx >= 0) && (idx <= 2);
                n_vec++;
                if (vld[j] !== ev) begin n_err++; $display("FAIL b2b_valid inst=%0d k=%0d got=%b exp=%b", j, k, vld[j], ev); end
                if (ev) begin
                    n_vec++;
                    if (dat[j] !== words[idx]) begin n_err++; $display("FAIL b2b_data inst=%0d k=%0d got=%h exp=%h", j, k, dat[j], words[idx]); end
                end
            end
        end
        rd_valid = 1'b0;
    endtask

    task automatic test_read_during_write;
        do_write(32'h30, 32'h0000_0001, 4'hF);
        rd_addr = 32'h30; rd_valid = 1'b1;
        wr_addr = 32'h30; wr_data = 32'h0000_0002; wr_strb = 4'hF; wr_valid = 1'b1;
        @(posedge clk); #1;
        rd_valid = 1'b0; wr_valid = 1'b0;
        for (int j = 0; j < 4; j++) exp_d[j] = (j == 1) ? 32'h2 : 32'h1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            for (int j = 0; j < 4; j++) begin
                if (k == lat_of(j)) begin
                    n_vec += 2;
                    if (vld[j] !== 1'b1) begin n_err++; $display("FAIL rdw_valid inst=%0d got=%b exp=1", j, vld[j]); end
                    if (dat[j] !== exp_d[j]) begin n_err++; $display("FAIL rdw_data inst=%0d got=%h exp=%h", j, dat[j], exp_d[j]); end
                end
            end
        end
        issue_read(32'h30);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            for (int j = 0; j < 4; j++) begin
                if (k == lat_of(j)) begin
                    n_vec += 2;
                    if (vld[j] !== 1'b1) begin n_err++; $display("FAIL rdw_next_valid inst=%0d got=%b exp=1", j, vld[j]); end
                    if (dat[j] !== 32'h2) begin n_err++; $display("FAIL rdw_next_data inst=%0d got=%h exp=00000002", j, dat[j]); end
                end
            end
        end
    endtask

    task automatic test_alias;
        do_write(32'h4000_0008, 32'hCAFE_BABE, 4'hF);
        issue_read(32'h08);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            for (int j = 0; j < 4; j++) begin
                if (k == lat_of(j)) begin
                    n_vec += 2;
                    if (vld[j] !== 1'b1) begin n_err++; $display("FAIL alias_valid inst=%0d got=%b exp=1", j, vld[j]); end
                    if (dat[j] !== 32'hCAFE_BABE) begin n_err++; $display("FAIL alias_data inst=%0d got=%h exp=cafebabe", j, dat[j]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_write(32'h20, 32'h5A5A_5A5A, 4'hF);
        issue_read(32'h20);
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            n_vec += 3;
            if (vld[j] !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid inst=%0d got=%b exp=0", j, vld[j]); end
            if (dat[j] !== 32'h0) begin n_err++; $display("FAIL mid_rst_data inst=%0d got=%h exp=0", j, dat[j]); end
            if (idn[j] !== 1'b0) begin n_err++; $display("FAIL mid_rst_init_done inst=%0d got=%b exp=0", j, idn[j]); end
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (vld[j] !== 1'b0) begin n_err++; $display("FAIL mid_flush_valid inst=%0d k=%0d got=%b exp=0", j, k, vld[j]); end
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (vld[j] !== 1'b0) begin n_err++; $display("FAIL mid_clear_valid inst=%0d k=%0d got=%b exp=0", j, k, vld[j]); end
            end
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                n_vec += 2;
                if (idn[j] !== (k == 16)) begin n_err++; $display("FAIL mid_init_done inst=%0d k=%0d got=%b exp=%b", j, k, idn[j], k == 16); end
                if (vld[j] !== 1'b0) begin n_err++; $display("FAIL mid_reclear_valid inst=%0d k=%0d got=%b exp=0", j, k, vld[j]); end
            end
        end
        issue_read(32'h20);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            for (int j = 0; j < 4; j++) begin
                if (k == lat_of(j)) begin
                    n_vec += 2;
                    if (vld[j] !== 1'b1) begin n_err++; $display("FAIL mid_post_valid inst=%0d got=%b exp=1", j, vld[j]); end
                    if (dat[j] !== 32'h0) begin n_err++; $display("FAIL mid_post_data inst=%0d got=%h exp=0", j, dat[j]); end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_strobe_latency();
        test_back_to_back();
        test_read_during_write();
        test_alias();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
